// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_pulse block: FSM state encoding and
// default parameter values.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam int DEF_CNT_WIDTH       = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 500;
    localparam int DEF_REPEAT_PERIOD   = 100;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronous
// active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability filter: d -> meta_r -> q
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer producing a registered level plus press/release strobes.
// Optional auto-repeat on long hold is built when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    // The sample that enters a CHK state is the first of the run, so the
    // check completes when the counter already holds DEBOUNCE_CYCLES-2.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);

    logic                 sync_in;
    state_t               state_r;
    state_t               state_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 cnt_done_s;
    logic                 press_s;
    logic                 release_s;
    logic                 repeat_s;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_in)
    );

    assign cnt_done_s = (cnt_r >= CNT_LAST);

    // Next-state and strobe decode
    always_comb begin
        state_s   = state_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_in) state_s = PRESS_CHK;
                else         state_s = IDLE;
            end
            PRESS_CHK: begin
                if (!sync_in) begin
                    state_s = IDLE;
                end else if (cnt_done_s) begin
                    state_s = HELD;
                    press_s = 1'b1;
                end else begin
                    state_s = PRESS_CHK;
                end
            end
            HELD: begin
                if (!sync_in) state_s = RELEASE_CHK;
                else          state_s = HELD;
            end
            RELEASE_CHK: begin
                if (sync_in) begin
                    state_s = HELD;
                end else if (cnt_done_s) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else begin
                    state_s = RELEASE_CHK;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Stability counter: cleared on every state entry, saturates at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (state_s != state_r) begin
            cnt_r <= '0;
        end else if (cnt_r != {CNT_WIDTH{1'b1}}) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [15:0] RPT_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_r;
    logic        rpt_first_r;
    logic        rpt_adv_s;

    // Repeat timer only advances on cycles spent in HELD; a RELEASE_CHK
    // excursion freezes it so a bounce does not restart the delay.
    assign rpt_adv_s = (state_r == HELD) && sync_in;
    assign repeat_s  = rpt_adv_s &&
                       (rpt_r == (rpt_first_r ? RPT_DELAY_LAST : RPT_PERIOD_LAST));

    // Auto-repeat timer
    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_r       <= 16'd0;
            rpt_first_r <= 1'b1;
        end else if (press_s) begin
            rpt_r       <= 16'd0;
            rpt_first_r <= 1'b1;
        end else if (repeat_s) begin
            rpt_r       <= 16'd0;
            rpt_first_r <= 1'b0;
        end else if (rpt_adv_s) begin
            rpt_r       <= rpt_r + 16'd1;
            rpt_first_r <= rpt_first_r;
        end else begin
            rpt_r       <= rpt_r;
            rpt_first_r <= rpt_first_r;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= (state_s == HELD) || (state_s == RELEASE_CHK);
            press_pulse   <= press_s | repeat_s;
            release_pulse <= release_s;
        end
    end

endmodule
